// File: rtl/matrix_pkg.sv
// Shared constants, state type and pattern helper for the LED matrix write path.
// The matrix output driver also takes OUTPUTS_PER_BOARD from here.
package matrix_pkg;

    localparam int OUTPUTS_PER_BOARD = 16;
    localparam logic [7:0] SYNC_BYTE = 8'hFF;
    localparam int PIXEL_ADDR_W = 9;
    localparam int PTR_W = 10;

    typedef enum logic [1:0] {
        HOST     = 2'd0,
        PAT_FILL = 2'd1,
        PAT_WAIT = 2'd2
    } ctrl_state_e;

    // Pattern pixel: (address + phase) mod 256 with bit 0 cleared.
    function automatic logic [7:0] pattern_pixel(input logic [7:0] addr, input logic [7:0] phase);
        logic [7:0] sum;
        sum = addr + phase;
        return {sum[7:1], 1'b0};
    endfunction

endpackage

// File: rtl/matrix_pattern_gen.sv
// Test-pattern sweep: fills addresses 0..N-1 one per cycle, waits PATTERN_DIV
// cycles, advances the phase by 4 and repeats until aborted.
module matrix_pattern_gen
    import matrix_pkg::*;
#(
    parameter int N           = 128,
    parameter int PATTERN_DIV = 400_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    output logic [PIXEL_ADDR_W-1:0] addr,
    output logic [7:0]              data,
    output logic                    strobe,
    output logic                    done
);
    localparam int WAIT_W = (PATTERN_DIV > 1) ? $clog2(PATTERN_DIV) : 1;

    logic                    fill_q, fill_d;
    logic                    wait_q, wait_d;
    logic [PIXEL_ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]              phase_q, phase_d;
    logic [WAIT_W-1:0]       wcnt_q, wcnt_d;

    always_comb begin
        fill_d  = fill_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        phase_d = phase_q;
        wcnt_d  = wcnt_q;
        if (abort) begin
            fill_d = 1'b0;
            wait_d = 1'b0;
        end else if (start) begin
            fill_d  = 1'b1;
            wait_d  = 1'b0;
            addr_d  = '0;
            phase_d = '0;
        end else if (fill_q) begin
            if (addr_q == PIXEL_ADDR_W'(N - 1)) begin
                fill_d = 1'b0;
                wait_d = 1'b1;
                wcnt_d = '0;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end else if (wait_q) begin
            if (wcnt_q == WAIT_W'(PATTERN_DIV - 1)) begin
                wait_d  = 1'b0;
                fill_d  = 1'b1;
                addr_d  = '0;
                phase_d = phase_q + 8'd4;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fill_q  <= 1'b0;
            wait_q  <= 1'b0;
            addr_q  <= '0;
            phase_q <= '0;
            wcnt_q  <= '0;
        end else begin
            fill_q  <= fill_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            phase_q <= phase_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign strobe = fill_q;
    assign addr   = addr_q;
    assign data   = pattern_pixel(addr_q[7:0], phase_q);
    assign done   = fill_q && (addr_q == PIXEL_ADDR_W'(N - 1));

endmodule

// File: rtl/matrix_write_ctrl.sv
// Arbitrates the host byte stream and the idle-timeout test pattern onto the
// matrix driver's single registered write port.
module matrix_write_ctrl
    import matrix_pkg::*;
#(
    parameter int BOARDS      = 2,
    parameter int ROWS        = 4,
    parameter int TIMEOUT     = 12_000_000,
    parameter int PATTERN_DIV = 400_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              host_data,
    input  logic                    host_valid,
    output logic                    host_ready,
    output logic [PIXEL_ADDR_W-1:0] address_out,
    output logic [7:0]              data_out,
    output logic                    write_strobe_out,
    output logic                    pattern_mode,
    output logic                    frame_done
);
    localparam int N      = BOARDS * OUTPUTS_PER_BOARD * ROWS;
    localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    if (N > 512 || N < 1) begin : g_size_check
        $error("matrix_write_ctrl: pixel count must be 1..512");
    end

    ctrl_state_e             state_q, state_d;
    logic [IDLE_W-1:0]       idle_q, idle_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic                    ready_q;
    logic                    strobe_q, strobe_d;
    logic                    done_q, done_d;
    logic                    mode_q, mode_d;
    logic [PIXEL_ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]              data_q, data_d;

    logic                    accept;
    logic                    pg_start, pg_abort, pg_strobe, pg_done;
    logic [PIXEL_ADDR_W-1:0] pg_addr;
    logic [7:0]              pg_data;

    matrix_pattern_gen #(
        .N           (N),
        .PATTERN_DIV (PATTERN_DIV)
    ) u_pattern (
        .clk    (clk),
        .rst    (rst),
        .start  (pg_start),
        .abort  (pg_abort),
        .addr   (pg_addr),
        .data   (pg_data),
        .strobe (pg_strobe),
        .done   (pg_done)
    );

    assign accept = host_valid && ready_q;

    always_comb begin
        state_d  = state_q;
        idle_d   = idle_q;
        ptr_d    = ptr_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        mode_d   = mode_q;
        addr_d   = addr_q;
        data_d   = data_q;
        pg_start = 1'b0;
        pg_abort = 1'b0;
        if (accept) begin
            // Host always wins, including on the timeout cycle and mid-pattern.
            idle_d   = '0;
            state_d  = HOST;
            mode_d   = 1'b0;
            pg_abort = (state_q != HOST);
            if (host_data == SYNC_BYTE) begin
                ptr_d = '0;
            end else if (ptr_q < PTR_W'(N)) begin
                strobe_d = 1'b1;
                addr_d   = ptr_q[PIXEL_ADDR_W-1:0];
                data_d   = host_data;
                done_d   = (ptr_q == PTR_W'(N - 1));
                ptr_d    = ptr_q + 1'b1;
            end
        end else begin
            unique case (state_q)
                HOST: begin
                    if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                        idle_d   = '0;
                        state_d  = PAT_FILL;
                        mode_d   = 1'b1;
                        pg_start = 1'b1;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
                PAT_FILL, PAT_WAIT: begin
                    if (pg_strobe) begin
                        strobe_d = 1'b1;
                        addr_d   = pg_addr;
                        data_d   = pg_data;
                        done_d   = pg_done;
                    end
                    if (pg_done) begin
                        state_d = PAT_WAIT;
                    end else if (pg_strobe) begin
                        state_d = PAT_FILL;
                    end
                end
                default: state_d = HOST;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= HOST;
            idle_q   <= '0;
            ptr_q    <= '0;
            ready_q  <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            mode_q   <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            idle_q   <= idle_d;
            ptr_q    <= ptr_d;
            ready_q  <= 1'b1;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            mode_q   <= mode_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    assign host_ready       = ready_q;
    assign write_strobe_out = strobe_q;
    assign frame_done       = done_q;
    assign pattern_mode     = mode_q;
    assign address_out      = addr_q;
    assign data_out         = data_q;

endmodule

// File: tb/tb_matrix_write_ctrl.sv
// Bench for matrix_write_ctrl: directed vector table, hand-written corner
// sequences and a randomized run checked against a frame-level reference model.
module tb_matrix_write_ctrl;
    localparam int BOARDS  = 2;
    localparam int ROWS    = 4;
    localparam int TIMEOUT = 100;
    localparam int PDIV    = 10;
    localparam int N       = BOARDS * 16 * ROWS;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] host_data = 8'd0;
    logic       host_valid = 1'b0;
    logic       host_ready;
    logic [8:0] address_out;
    logic [7:0] data_out;
    logic       write_strobe_out;
    logic       pattern_mode;
    logic       frame_done;

    always #5 clk = ~clk;

    matrix_write_ctrl #(
        .BOARDS      (BOARDS),
        .ROWS        (ROWS),
        .TIMEOUT     (TIMEOUT),
        .PATTERN_DIV (PDIV)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .host_data        (host_data),
        .host_valid       (host_valid),
        .host_ready       (host_ready),
        .address_out      (address_out),
        .data_out         (data_out),
        .write_strobe_out (write_strobe_out),
        .pattern_mode     (pattern_mode),
        .frame_done       (frame_done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: host pointer with lock at N, idle count, and the pattern
    // expressed as position within a repeating (N writes + PDIV gap) period.
    int m_ptr, m_idle, m_pos;
    bit m_pat, m_ready;
    bit e_strobe, e_done;
    int e_addr, e_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] obs();
        return {11'd0, host_ready, pattern_mode, write_strobe_out, frame_done, address_out, data_out};
    endfunction

    function automatic logic [31:0] exp_vec();
        return {11'd0, m_ready, m_pat, e_strobe, e_done, 9'(e_addr), 8'(e_data)};
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_idle = 0; m_pos = 0; m_pat = 0; m_ready = 0;
        e_strobe = 0; e_done = 0; e_addr = 0; e_data = 0;
    endtask

    task automatic model_step(input bit acc, input logic [7:0] d);
        int off, phase;
        e_strobe = 0;
        e_done   = 0;
        if (acc) begin
            m_idle = 0;
            m_pat  = 0;
            if (d == 8'hFF) m_ptr = 0;
            else if (m_ptr < N) begin
                e_strobe = 1; e_addr = m_ptr; e_data = d; e_done = (m_ptr == N - 1);
                m_ptr++;
            end
        end else if (!m_pat) begin
            if (m_idle == TIMEOUT - 1) begin
                m_pat = 1; m_pos = 0; m_idle = 0;
            end else m_idle++;
        end else begin
            off   = m_pos % (N + PDIV);
            phase = (4 * (m_pos / (N + PDIV))) % 256;
            if (off < N) begin
                e_strobe = 1; e_addr = off; e_data = ((off + phase) % 256) & 'hFE;
                e_done = (off == N - 1);
            end
            m_pos++;
        end
    endtask

    task automatic cycle(input bit v, input logic [7:0] d);
        host_valid = v;
        host_data  = d;
        model_step(v && m_ready, d);
        @(posedge clk);
        #1;
        m_ready = 1;
        check("model", obs(), exp_vec());
        host_valid = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        host_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        check("reset_outputs", obs(), 32'd0);
        rst = 1;
    endtask

    function automatic logic [7:0] rand_pixel();
        return 8'($urandom_range(0, 254));
    endfunction

    typedef struct {
        bit         v;
        logic [7:0] d;
        bit         s;
        logic [8:0] a;
        logic [7:0] dat;
        bit         done;
        bit         mode;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n_str, done_addr, gap;
        bit found;
        logic [7:0] v;

        tbl[0] = '{1, 8'hFF, 0, 9'd0, 8'h00, 0, 0};
        tbl[1] = '{1, 8'h10, 1, 9'd0, 8'h10, 0, 0};
        tbl[2] = '{1, 8'h20, 1, 9'd1, 8'h20, 0, 0};
        tbl[3] = '{0, 8'h00, 0, 9'd1, 8'h20, 0, 0};
        tbl[4] = '{1, 8'hFF, 0, 9'd1, 8'h20, 0, 0};

        // Reset and release
        do_reset();
        cycle(0, 8'h00);
        check("ready_after_release", {pattern_mode, host_ready}, 2'b01);

        // Directed vector table
        for (int i = 0; i < 5; i++) begin
            cycle(tbl[i].v, tbl[i].d);
            check($sformatf("vec%0d", i),
                  {write_strobe_out, address_out, data_out, frame_done, pattern_mode},
                  {tbl[i].s, tbl[i].a, tbl[i].dat, tbl[i].done, tbl[i].mode});
        end

        // Full host frame, lock, resync
        n_str = 0; done_addr = -1;
        for (int i = 0; i < N; i++) begin
            cycle(1, rand_pixel());
            if (write_strobe_out) n_str++;
            if (frame_done) done_addr = address_out;
        end
        check("frame_strobes", n_str, N);
        check("frame_done_addr", done_addr, N - 1);
        cycle(1, 8'h5A);
        check("locked_no_strobe", write_strobe_out, 1'b0);
        cycle(1, 8'hFF);
        cycle(1, 8'h55);
        check("resync_write", {write_strobe_out, address_out, data_out}, {1'b1, 9'd0, 8'h55});

        // Timeout into pattern mode
        do_reset();
        k = 0;
        while (!pattern_mode && k < 300) begin
            cycle(0, 8'h00);
            k++;
        end
        check("timeout_cycles", k, TIMEOUT);
        n_str = 0; done_addr = -1;
        for (int i = 0; i < N; i++) begin
            cycle(0, 8'h00);
            if (write_strobe_out && data_out == (address_out[7:0] & 8'hFE)) n_str++;
            if (frame_done) done_addr = address_out;
        end
        check("pattern_frame0_writes", n_str, N);
        check("pattern_frame0_done", done_addr, N - 1);
        gap = 0;
        cycle(0, 8'h00);
        while (!write_strobe_out && gap < 50) begin
            gap++;
            cycle(0, 8'h00);
        end
        check("pattern_wait_gap", gap, PDIV);
        check("pattern_phase4", {write_strobe_out, address_out, data_out}, {1'b1, 9'd0, 8'h04});

        // Host preemption during pattern fill
        do_reset();
        cycle(1, 8'hFF);
        for (int i = 0; i < 5; i++) cycle(1, rand_pixel());
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            cycle(0, 8'h00);
            if (write_strobe_out && pattern_mode && address_out == 9'd39) found = 1;
        end
        check("preempt_reached_addr39", found, 1'b1);
        cycle(1, 8'h33);
        check("preempt_write", {write_strobe_out, pattern_mode, address_out, data_out},
              {1'b1, 1'b0, 9'd5, 8'h33});
        n_str = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(0, 8'h00);
            if (write_strobe_out) n_str++;
        end
        check("preempt_no_more_pattern", n_str, 0);

        // Accept on the exact timeout cycle
        do_reset();
        repeat (TIMEOUT - 1) cycle(0, 8'h00);
        check("pre_timeout_mode", pattern_mode, 1'b0);
        cycle(1, 8'h42);
        check("timeout_tie_write", {write_strobe_out, pattern_mode, address_out, data_out},
              {1'b1, 1'b0, 9'd0, 8'h42});
        cycle(0, 8'h00);
        check("timeout_tie_stays_host", pattern_mode, 1'b0);

        // Reset mid-frame at pointer 60
        do_reset();
        cycle(1, 8'hFF);
        for (int i = 0; i < 60; i++) cycle(1, rand_pixel());
        do_reset();
        cycle(0, 8'h00);
        cycle(1, 8'h77);
        check("post_reset_write", {write_strobe_out, address_out, data_out}, {1'b1, 9'd0, 8'h77});

        // Randomized traffic with idle stretches long enough to enter pattern mode
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                repeat ($urandom_range(50, 400)) cycle(0, 8'h00);
            end else begin
                v = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
                cycle($urandom_range(0, 3) != 0, v);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
